ir_prefetch_queue: RTL and testbench
====================================

Name: ir_prefetch_queue

Overview:
- Parametrised successor to the single-stage instruction register.
- Buffers up to DEPTH fetched instruction words in a prefetch FIFO, with a valid/ready handshake toward fetch.
- Loads the head word into the architectural IR on en_ir.
- Presents decoded opcode/operand fields to the control unit; flush discards all prefetched and current instructions on a branch or redirect.

Parameters:
- WIDTH, 16, instruction word width in bits.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- OPC_W, 4, opcode field width, taken from the MSBs of the IR; 1 <= OPC_W < WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  discard FIFO contents and invalidate IR.
- d_in  in  WIDTH  fetched instruction word.
- in_valid  in  1  d_in holds a valid word.
- in_ready  out  1  FIFO can accept a word this cycle.
- en_ir  in  1  advance: load the FIFO head into the IR.
- d_out  out  WIDTH  current IR contents.
- ir_valid  out  1  d_out holds a live instruction.
- opcode  out  OPC_W  d_out[WIDTH-1 : WIDTH-OPC_W].
- operand  out  WIDTH-OPC_W  d_out[WIDTH-OPC_W-1 : 0].
- count  out  clog2(DEPTH+1)  FIFO occupancy, excluding the IR.

Behaviour:
- Reset (rst=0, asynchronous):
  - d_out=0, ir_valid=0, count=0, read/write pointers=0.
  - in_ready=1 once rst deasserts.
  - Reset asserted mid-operation drops all words immediately.
- in_ready = (count < DEPTH).
  - Combinational from registered count only; no same-cycle pass-through credit from a pop.
- Push: in_valid && in_ready at a rising edge writes d_in at wr_ptr; wr_ptr increments modulo DEPTH.
- Push attempt while full: word is not accepted; the source holds d_in/in_valid.
- Pop: en_ir && count>0 at a rising edge:
  - d_out <= head entry, ir_valid <= 1.
  - rd_ptr increments modulo DEPTH.
- en_ir && count==0:
  - ir_valid <= 0; d_out holds its previous value.
  - No bypass: a word pushed in the same cycle lands in the FIFO and is not visible in the IR.
- en_ir=0: d_out and ir_valid hold (same as the one-stage IR with en_ir low).
- Simultaneous push and pop (not full): count unchanged; both pointers advance.
- Occupancy and latency:
  - count = count + push - pop.
  - Latency from accepted push to d_out is at least 2 edges: push, then en_ir.
- Flush (synchronous, highest priority):
  - count <= 0, pointers <= 0, ir_valid <= 0, d_out <= 0.
  - Any push or pop in that cycle is ignored.
  - in_ready is still computed from the pre-flush count.
- opcode and operand are pure combinational slices of d_out.
  - Valid only when ir_valid=1; they are still driven from d_out otherwise.
- Pointer wrap:
  - Pointers are clog2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by count, not by pointer compare.
- FIFO storage needs no reset; unread entries are never visible on d_out.

Decomposition:
- Shared package ir_pkg:
  - IR_WIDTH_DEF=16, IR_DEPTH_DEF=4, IR_OPC_W_DEF=4.
  - IR_NOP constant 16'h0000, the reset/flush IR value.
  - An opcode enumeration typedef for the control unit.
- Sub-module ir_fifo (WIDTH, DEPTH):
  - Storage array, pointers, count, push/pop/flush.
  - ir_prefetch_queue wraps it with the IR register and field slicing.

Test Plan:
- Reset then fill: with rst=0, d_out=0, ir_valid=0, in_ready=0 or 1 irrelevant. After release, push 16'h00B1, 16'h1131, 16'h80B1, 16'hCCB1 -> count=4, in_ready=0.
- Push while full: a 5th push of 16'h11F1 is held by the source -> count stays 4 until a pop. Then en_ir -> d_out=16'h00B1, opcode=4'h0, operand=12'h0B1, ir_valid=1, in_ready=1.
- Simultaneous push/pop: with count=3, en_ir=1 and push 16'h1131 in one cycle -> count stays 3, d_out=next head. Drain order matches push order across a pointer wrap.
- Empty advance: count=0, en_ir=1 with a simultaneous push of 16'h80B1 -> ir_valid=0, d_out held, count=1. Next en_ir -> d_out=16'h80B1, opcode=4'h8.
- Flush priority: count=2, ir_valid=1, flush=1 with en_ir=1 and in_valid=1 -> next cycle count=0, ir_valid=0, d_out=0, the pushed word is discarded.
- Async reset mid-stream: rst=0 asserted between clock edges with count=3 -> d_out=0, ir_valid=0, count=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register prefetch queue and the
// control unit that decodes its opcode field.
package ir_pkg;

    localparam int unsigned IR_WIDTH_DEF = 16;
    localparam int unsigned IR_DEPTH_DEF = 4;
    localparam int unsigned IR_OPC_W_DEF = 4;

    // IR contents after reset or flush; decodes as a no-operation.
    localparam logic [15:0] IR_NOP = 16'h0000;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_OR    = 4'h4,
        OP_XOR   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_LDI   = 4'hA,
        OP_MOV   = 4'hB,
        OP_JMP   = 4'hC,
        OP_BZ    = 4'hD,
        OP_CALL  = 4'hE,
        OP_HALT  = 4'hF
    } ir_opcode_e;

endpackage

// File: rtl/ir_fifo.sv
// Prefetch FIFO: power-of-two ring buffer whose full/empty state comes from
// the occupancy count rather than from pointer comparison.
module ir_fifo
    import ir_pkg::*;
#(
    parameter int unsigned WIDTH = IR_WIDTH_DEF,
    parameter int unsigned DEPTH = IR_DEPTH_DEF,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_en,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_fire,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_fire;

    // Ready depends on the registered count only, so a pop never frees a slot
    // for a push in the same cycle.
    assign push_ready = (count < CW'(DEPTH));
    assign push_fire  = push_valid && push_ready && !flush;
    assign pop_fire   = pop_en && (count != '0) && !flush;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + PW'(1);
            if (pop_fire)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_fire) - CW'(pop_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a prefetch FIFO; exposes the decoded opcode and
// operand slices of the current IR to the control unit.
module ir_prefetch_queue
    import ir_pkg::*;
#(
    parameter int unsigned WIDTH = IR_WIDTH_DEF,
    parameter int unsigned DEPTH = IR_DEPTH_DEF,
    parameter int unsigned OPC_W = IR_OPC_W_DEF,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       d_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   en_ir,
    output logic [WIDTH-1:0]       d_out,
    output logic                   ir_valid,
    output logic [OPC_W-1:0]       opcode,
    output logic [WIDTH-OPC_W-1:0] operand,
    output logic [CW-1:0]          count
);

    logic [WIDTH-1:0] head;
    logic             pop_fire;

    ir_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (in_valid),
        .push_data  (d_in),
        .push_ready (in_ready),
        .pop_en     (en_ir),
        .pop_data   (head),
        .pop_fire   (pop_fire),
        .count      (count)
    );

    // An advance on an empty FIFO invalidates the IR but keeps its last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out    <= WIDTH'(IR_NOP);
            ir_valid <= 1'b0;
        end else if (flush) begin
            d_out    <= WIDTH'(IR_NOP);
            ir_valid <= 1'b0;
        end else if (en_ir) begin
            ir_valid <= pop_fire;
            if (pop_fire) d_out <= head;
        end
    end

    assign opcode  = d_out[WIDTH-1 -: OPC_W];
    assign operand = d_out[WIDTH-OPC_W-1:0];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios with literal expectations,
// then random traffic compared every cycle against a queue-based model.
module tb_ir_prefetch_queue;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OPC_W = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   flush = 1'b0;
    logic [WIDTH-1:0]       d_in = '0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic                   en_ir = 1'b0;
    logic [WIDTH-1:0]       d_out;
    logic                   ir_valid;
    logic [OPC_W-1:0]       opcode;
    logic [WIDTH-OPC_W-1:0] operand;
    logic [CW-1:0]          count;

    int n_checks = 0;
    int n_fail   = 0;

    ir_prefetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OPC_W (OPC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .d_in     (d_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .en_ir    (en_ir),
        .d_out    (d_out),
        .ir_valid (ir_valid),
        .opcode   (opcode),
        .operand  (operand),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Reference model: words waiting in the FIFO, plus the IR itself.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_irv  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_dout = '0;
            m_irv  = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_dout = '0;
            m_irv  = 1'b0;
        end else begin
            int pre;
            pre = m_q.size();
            if (en_ir) begin
                if (pre > 0) begin
                    m_dout = m_q.pop_front();
                    m_irv  = 1'b1;
                end else begin
                    m_irv = 1'b0;
                end
            end
            if (in_valid && pre < DEPTH) m_q.push_back(d_in);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            logic [WIDTH-1:0] md;
            md = m_dout;
            chk("model_d_out",    32'(d_out),    32'(md));
            chk("model_ir_valid", 32'(ir_valid), 32'(m_irv));
            chk("model_count",    32'(count),    32'(m_q.size()));
            chk("model_in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
            chk("model_opcode",   32'(opcode),   32'(md[WIDTH-1:WIDTH-OPC_W]));
            chk("model_operand",  32'(operand),  32'(md[WIDTH-OPC_W-1:0]));
        end
    end

    // Apply one cycle of inputs; returns #1 after the capturing edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic en, input logic fl);
        in_valid = iv;
        d_in     = d;
        en_ir    = en;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        en_ir    = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_d_out",    32'(d_out),    32'h0);
        chk("reset_ir_valid", 32'(ir_valid), 32'h0);
        chk("reset_count",    32'(count),    32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(in_ready), 32'h1);

        cycle(1'b1, 16'h00B1, 1'b0, 1'b0);
        cycle(1'b1, 16'h1131, 1'b0, 1'b0);
        cycle(1'b1, 16'h80B1, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCB1, 1'b0, 1'b0);
        chk("fill_count",    32'(count),    32'h4);
        chk("fill_in_ready", 32'(in_ready), 32'h0);

        cycle(1'b1, 16'h11F1, 1'b0, 1'b0);
        cycle(1'b1, 16'h11F1, 1'b0, 1'b0);
        chk("full_hold_count", 32'(count), 32'h4);
        // Pop while the held push is still presented: full, so it is refused.
        cycle(1'b1, 16'h11F1, 1'b1, 1'b0);
        chk("pop1_d_out",    32'(d_out),    32'h00B1);
        chk("pop1_opcode",   32'(opcode),   32'h0);
        chk("pop1_operand",  32'(operand),  32'h0B1);
        chk("pop1_ir_valid", 32'(ir_valid), 32'h1);
        chk("pop1_in_ready", 32'(in_ready), 32'h1);
        chk("pop1_count",    32'(count),    32'h3);

        cycle(1'b1, 16'h1131, 1'b1, 1'b0);
        chk("pushpop_count", 32'(count), 32'h3);
        chk("pushpop_d_out", 32'(d_out), 32'h1131);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_a", 32'(d_out), 32'h80B1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_b", 32'(d_out), 32'hCCB1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("drain_c_wrap", 32'(d_out), 32'h1131);
        chk("drain_count",  32'(count), 32'h0);

        cycle(1'b1, 16'h80B1, 1'b1, 1'b0);
        chk("empty_adv_ir_valid", 32'(ir_valid), 32'h0);
        chk("empty_adv_d_out",    32'(d_out),    32'h1131);
        chk("empty_adv_count",    32'(count),    32'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("after_empty_d_out",  32'(d_out),  32'h80B1);
        chk("after_empty_opcode", 32'(opcode), 32'h8);

        cycle(1'b1, 16'hA123, 1'b0, 1'b0);
        cycle(1'b1, 16'hB456, 1'b0, 1'b0);
        chk("preflush_count", 32'(count), 32'h2);
        cycle(1'b1, 16'hC789, 1'b1, 1'b1);
        chk("flush_count",    32'(count),    32'h0);
        chk("flush_ir_valid", 32'(ir_valid), 32'h0);
        chk("flush_d_out",    32'(d_out),    32'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("postflush_ir_valid", 32'(ir_valid), 32'h0);
        chk("postflush_count",    32'(count),    32'h0);

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) < 60, WIDTH'($urandom),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);
        end

        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0, 1'b0);
        cycle(1'b1, 16'h4444, 1'b1, 1'b0);
        chk("prereset_count", 32'(count), 32'h3);
        chk("prereset_d_out", 32'(d_out), 32'h1111);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_d_out",    32'(d_out),    32'h0);
        chk("async_rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("async_rst_count",    32'(count),    32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 70, WIDTH'($urandom),
                  $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
